// File: rtl/ysyx_24110006_pc_unit_if.sv
// Fetch-PC bus: IFU fetch handshake plus commit/redirect feedback.
// The master modport is the PC unit side; the slave modport is the IFU/commit side.
interface ysyx_24110006_pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_pc;
  logic            o_epoch;
  logic            i_commit_valid;
  logic            i_jump;
  logic [XLEN-1:0] i_upc;
  logic            i_trap;
  logic [XLEN-1:0] i_trap_vec;
  logic [2:0]      o_inflight;

  modport master (
    output o_valid, o_pc, o_epoch, o_inflight,
    input  i_ready, i_commit_valid, i_jump, i_upc, i_trap, i_trap_vec
  );

  modport slave (
    input  o_valid, o_pc, o_epoch, o_inflight,
    output i_ready, i_commit_valid, i_jump, i_upc, i_trap, i_trap_vec
  );
endinterface

// File: rtl/ysyx_24110006_pc_unit.sv
// Fetch-PC generator: issues sequential PCs, bounds in-flight instructions and
// applies commit-time trap/jump redirects with an epoch tag for wrong-path squashing.
module ysyx_24110006_pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VEC    = XLEN'(32'h8000_0000),
  parameter int unsigned     INC          = 4,
  parameter int unsigned     MAX_INFLIGHT = 1
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  ysyx_24110006_pc_unit_if.master           bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              epoch_q, epoch_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              valid_q, valid_d;

  logic fire;
  logic redirect;

  assign fire     = valid_q & bus.i_ready;
  assign redirect = bus.i_commit_valid & (bus.i_trap | bus.i_jump);

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one dead cycle in WAIT, then ISSUE until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:  state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_ISSUE;
      default:  state_d = ST_WAIT;
    endcase
  end

  // Datapath next values; valid is precomputed so it depends only on registers
  always_comb begin
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    inflight_d = inflight_q;
    valid_d    = 1'b0;

    if (redirect) begin
      // Any fire this cycle is wrong-path and is neither counted nor advanced
      pc_d       = bus.i_trap ? bus.i_trap_vec : bus.i_upc;
      epoch_d    = ~epoch_q;
      inflight_d = '0;
    end else begin
      if (fire) begin
        pc_d = pc_q + XLEN'(INC);
      end
      case ({fire, bus.i_commit_valid})
        2'b10:   inflight_d = inflight_q + CNT_W'(1);
        2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - CNT_W'(1);
        default: inflight_d = inflight_q;
      endcase
    end

    valid_d = (state_d == ST_ISSUE) && (inflight_d < CNT_W'(MAX_INFLIGHT));
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pc_q       <= RESET_VEC;
      epoch_q    <= 1'b0;
      inflight_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_pc       = pc_q;
  assign bus.o_epoch    = epoch_q;
  assign bus.o_inflight = inflight_q;

  // Committing with nothing in flight is a pipeline bug
  commit_needs_inflight: assert property (
    @(posedge i_clock) disable iff (i_reset)
    bus.i_commit_valid |-> (inflight_q != '0)
  );

endmodule
